// File: rtl/y_out_checker_if.sv
// Bus interface for y_out_checker: stimulus/expected-value side (master)
// and checker side (slave). The CHECK_MASK_EN macro adds the exp_mask lane.
interface y_out_checker_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
);
    localparam int QCW = $clog2(DEPTH) + 1;

    // Inputs to the checker
    logic             start;
    logic             exp_wr;
    logic [7:0]       exp_data;
`ifdef CHECK_MASK_EN
    logic [7:0]       exp_mask;
`endif
    logic             sample_valid;
    logic [7:0]       y_in;
    logic             flag_in;

    // Outputs from the checker
    logic             busy;
    logic             done;
    logic             pass;
    logic             mismatch;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [7:0]       first_fail_got;
    logic [7:0]       first_fail_exp;
    logic [7:0]       first_fail_idx;
    logic             first_fail_flag;
    logic             underrun;
    logic             overflow;
    logic [QCW-1:0]   q_count;

`ifdef CHECK_MASK_EN
    modport master (
        output start, exp_wr, exp_data, exp_mask, sample_valid, y_in, flag_in,
        input  busy, done, pass, mismatch, pass_cnt, fail_cnt,
               first_fail_got, first_fail_exp, first_fail_idx, first_fail_flag,
               underrun, overflow, q_count
    );

    modport slave (
        input  start, exp_wr, exp_data, exp_mask, sample_valid, y_in, flag_in,
        output busy, done, pass, mismatch, pass_cnt, fail_cnt,
               first_fail_got, first_fail_exp, first_fail_idx, first_fail_flag,
               underrun, overflow, q_count
    );
`else
    modport master (
        output start, exp_wr, exp_data, sample_valid, y_in, flag_in,
        input  busy, done, pass, mismatch, pass_cnt, fail_cnt,
               first_fail_got, first_fail_exp, first_fail_idx, first_fail_flag,
               underrun, overflow, q_count
    );

    modport slave (
        input  start, exp_wr, exp_data, sample_valid, y_in, flag_in,
        output busy, done, pass, mismatch, pass_cnt, fail_cnt,
               first_fail_got, first_fail_exp, first_fail_idx, first_fail_flag,
               underrun, overflow, q_count
    );
`endif

endinterface

// File: rtl/y_out_checker.sv
// y_out_checker: compares sampled DUT y_out values against a queue of
// expected values, keeping saturating pass/fail counts, first-failure
// capture and sticky underrun/overflow flags, with a done/pass summary.
// Optional feature macro: CHECK_MASK_EN (per-entry don't-care mask).
module y_out_checker #(
    parameter int DEPTH      = 8,
    parameter int NUM_CHECKS = 4,
    parameter int CNT_W      = 8
) (
    input logic            clk,
    input logic            rst,
    y_out_checker_if.slave bus
);

    localparam int               AW       = $clog2(DEPTH);
    localparam int               QCW      = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]       LAST_IDX = 8'(NUM_CHECKS);
    localparam logic [QCW-1:0]   FULL_CNT = QCW'(DEPTH);

`ifdef CHECK_MASK_EN
    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] data;
    } entry_t;
`else
    typedef struct packed {
        logic [7:0] data;
    } entry_t;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             busy_c;
    logic             done_c;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [QCW-1:0]   count;

    logic             empty;
    logic             full;
    logic             check_en;
    logic             do_pop;
    logic             do_push;
    logic             drop;
    logic             last_sample;
    logic [7:0]       exp_val;
    logic [7:0]       mask_val;
    logic             sample_ok;

    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [7:0]       idx;
    logic             mismatch;
    logic             underrun;
    logic             overflow;
    logic [7:0]       ff_got;
    logic [7:0]       ff_exp;
    logic [7:0]       ff_idx;
    logic             ff_flag;

    // Queue status and the per-cycle check/push/pop decisions
    always_comb begin
        empty       = (count == '0);
        full        = (count == FULL_CNT);
        // A start in the same cycle wins: the sample is not checked.
        check_en    = (state == S_RUN) && bus.sample_valid && !bus.start;
        do_pop      = check_en && !empty;
        // A full queue still accepts a push if the head leaves this cycle.
        do_push     = bus.exp_wr && (!full || do_pop);
        drop        = bus.exp_wr && full && !do_pop;
        last_sample = check_en && ((idx + 8'd1) == LAST_IDX);
    end

    // Expected value / mask selection and the comparison itself
    always_comb begin
        head     = mem[rd_ptr];
        wr_entry = '0;
        wr_entry.data = bus.exp_data;
`ifdef CHECK_MASK_EN
        wr_entry.mask = bus.exp_mask;
        mask_val      = empty ? 8'hFF : head.mask;
`else
        mask_val      = 8'hFF;
`endif
        exp_val   = empty ? 8'h00 : head.data;
        // An underrun is always a failure, whatever y_in happens to be.
        sample_ok = !empty && (((exp_val ^ bus.y_in) & mask_val) == 8'h00);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and state-decoded outputs
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_RUN;
            end
            S_RUN: begin
                busy_c = 1'b1;
                if (bus.start) begin
                    state_next = S_RUN;
                end else if (last_sample) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.start) state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + QCW'(1);
                2'b01:   count <= count - QCW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only read when
        // count says they were written, so clearing it would be wasted logic.
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    // Scoreboard: counters, sample index, sticky flags, first-failure capture
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            idx      <= '0;
            mismatch <= 1'b0;
            underrun <= 1'b0;
            overflow <= 1'b0;
            ff_got   <= '0;
            ff_exp   <= '0;
            ff_idx   <= '0;
            ff_flag  <= 1'b0;
        end else begin
            mismatch <= check_en && !sample_ok;

            if (bus.start) begin
                pass_cnt <= '0;
                fail_cnt <= '0;
                idx      <= '0;
                underrun <= 1'b0;
                ff_got   <= '0;
                ff_exp   <= '0;
                ff_idx   <= '0;
                ff_flag  <= 1'b0;
            end else if (check_en) begin
                idx <= idx + 8'd1;
                if (empty) underrun <= 1'b1;
                if (sample_ok) begin
                    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
                end else begin
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
                    if (fail_cnt == '0) begin
                        ff_got  <= bus.y_in;
                        ff_exp  <= exp_val;
                        ff_idx  <= idx;
                        ff_flag <= bus.flag_in;
                    end
                end
            end

            // A push dropped in the start cycle still registers as overflow.
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.start) begin
                overflow <= 1'b0;
            end
        end
    end

    assign bus.busy            = busy_c;
    assign bus.done            = done_c;
    assign bus.pass            = done_c && (fail_cnt == '0) && !underrun && !overflow;
    assign bus.mismatch        = mismatch;
    assign bus.pass_cnt        = pass_cnt;
    assign bus.fail_cnt        = fail_cnt;
    assign bus.first_fail_got  = ff_got;
    assign bus.first_fail_exp  = ff_exp;
    assign bus.first_fail_idx  = ff_idx;
    assign bus.first_fail_flag = ff_flag;
    assign bus.underrun        = underrun;
    assign bus.overflow        = overflow;
    assign bus.q_count         = count;

endmodule

// File: tb/tb_y_out_checker.sv
// Testbench for y_out_checker: table-driven vectors, hand-written corner
// sequences and a randomized phase against a queue-based reference model.
module tb_y_out_checker;

    localparam int DEPTH      = 8;
    localparam int NUM_CHECKS = 4;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    y_out_checker_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    y_out_checker #(
        .DEPTH(DEPTH),
        .NUM_CHECKS(NUM_CHECKS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit st, input bit wr, input logic [7:0] d, input logic [7:0] m,
                         input bit sv, input logic [7:0] y, input bit fl);
        bus.start        = st;
        bus.exp_wr       = wr;
        bus.exp_data     = d;
`ifdef CHECK_MASK_EN
        bus.exp_mask     = m;
`endif
        bus.sample_valid = sv;
        bus.y_in         = y;
        bus.flag_in      = fl;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'hFF, 0, 8'h00, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        drive(0, 1, d, 8'hFF, 0, 8'h00, 0);
        tick();
    endtask

    task automatic sample(input logic [7:0] y, input bit fl);
        drive(0, 0, 8'h00, 8'hFF, 1, y, fl);
        tick();
    endtask

    task automatic do_start();
        drive(1, 0, 8'h00, 8'hFF, 0, 8'h00, 0);
        tick();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model (queue-based) ----------------
    logic [7:0] mq[$];
    logic [7:0] mkq[$];
    int         m_mode;        // 0 idle, 1 running, 2 finished
    int         m_pc, m_fc, m_idx;
    bit         m_mm, m_under, m_over;
    logic [7:0] m_ffg, m_ffe, m_ffi;
    bit         m_fff;

    task automatic model_clear_results();
        m_pc = 0; m_fc = 0; m_idx = 0; m_under = 0;
        m_ffg = 0; m_ffe = 0; m_ffi = 0; m_fff = 0;
    endtask

    task automatic model_step(input bit r, input bit st, input bit wr, input logic [7:0] d,
                              input logic [7:0] m, input bit sv, input logic [7:0] y, input bit fl);
        bit         was_full, popped, ok;
        logic [7:0] e, k;
        if (r) begin
            mq.delete(); mkq.delete();
            m_mode = 0; m_mm = 0; m_over = 0;
            model_clear_results();
            return;
        end
        was_full = (mq.size() == DEPTH);
        popped   = 0;
        m_mm     = 0;
        if (st) begin
            m_mode = 1;
            m_over = 0;
            model_clear_results();
        end else if (m_mode == 1 && sv) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                k = mkq.pop_front();
                popped = 1;
                ok = ((e ^ y) & k) == 8'h00;
            end else begin
                e = 8'h00;
                ok = 0;
                m_under = 1;
            end
            if (ok) begin
                if (m_pc < CNT_MAX) m_pc++;
            end else begin
                if (m_fc == 0) begin
                    m_ffg = y; m_ffe = e; m_ffi = 8'(m_idx); m_fff = fl;
                end
                if (m_fc < CNT_MAX) m_fc++;
                m_mm = 1;
            end
            m_idx++;
            if (m_idx == NUM_CHECKS) m_mode = 2;
        end
        if (wr) begin
            if (was_full && !popped) m_over = 1;
            else begin
                mq.push_back(d);
                mkq.push_back(m);
            end
        end
    endtask

    task automatic compare_model(input int cyc);
        bit exp_done;
        exp_done = (m_mode == 2);
        check($sformatf("rnd%0d.q_count", cyc), bus.q_count, mq.size());
        check($sformatf("rnd%0d.pass_cnt", cyc), bus.pass_cnt, m_pc);
        check($sformatf("rnd%0d.fail_cnt", cyc), bus.fail_cnt, m_fc);
        check($sformatf("rnd%0d.mismatch", cyc), bus.mismatch, m_mm);
        check($sformatf("rnd%0d.busy", cyc), bus.busy, m_mode == 1);
        check($sformatf("rnd%0d.done", cyc), bus.done, exp_done);
        check($sformatf("rnd%0d.pass", cyc), bus.pass,
              exp_done && m_fc == 0 && !m_under && !m_over);
        check($sformatf("rnd%0d.underrun", cyc), bus.underrun, m_under);
        check($sformatf("rnd%0d.overflow", cyc), bus.overflow, m_over);
        check($sformatf("rnd%0d.ff_got", cyc), bus.first_fail_got, m_ffg);
        check($sformatf("rnd%0d.ff_exp", cyc), bus.first_fail_exp, m_ffe);
        check($sformatf("rnd%0d.ff_idx", cyc), bus.first_fail_idx, m_ffi);
        check($sformatf("rnd%0d.ff_flag", cyc), bus.first_fail_flag, m_fff);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         st, wr;
        logic [7:0] d;
        bit         sv;
        logic [7:0] y;
        bit         fl;
        int         q, pc, fc;
        bit         mm, busy, done, pass;
    } vec_t;

    function automatic vec_t mk(bit st, bit wr, logic [7:0] d, bit sv, logic [7:0] y, bit fl,
                                int q, int pc, int fc, bit mm, bit busy, bit done, bit pass);
        vec_t v;
        v.st = st; v.wr = wr; v.d = d; v.sv = sv; v.y = y; v.fl = fl;
        v.q = q; v.pc = pc; v.fc = fc; v.mm = mm; v.busy = busy; v.done = done; v.pass = pass;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic pass run, then a second run with one failing sample.
        //                st wr data  sv y     fl  q pc fc mm bsy dn ps
        vecs[0]  = mk(0, 1, 8'h21, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 8'h01, 0, 8'h00, 0, 2, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h0f, 0, 8'h00, 0, 3, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 8'hf0, 0, 8'h00, 0, 4, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 8'h00, 0, 8'h00, 0, 4, 0, 0, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 8'h00, 1, 8'h21, 0, 3, 1, 0, 0, 1, 0, 0);
        vecs[6]  = mk(0, 0, 8'h00, 1, 8'h01, 0, 2, 2, 0, 0, 1, 0, 0);
        vecs[7]  = mk(0, 0, 8'h00, 1, 8'h0f, 0, 1, 3, 0, 0, 1, 0, 0);
        vecs[8]  = mk(0, 0, 8'h00, 1, 8'hf0, 0, 0, 4, 0, 0, 0, 1, 1);
        vecs[9]  = mk(0, 0, 8'h00, 1, 8'h99, 0, 0, 4, 0, 0, 0, 1, 1);
        vecs[10] = mk(0, 1, 8'h21, 0, 8'h00, 0, 1, 4, 0, 0, 0, 1, 1);
        vecs[11] = mk(0, 1, 8'h01, 0, 8'h00, 0, 2, 4, 0, 0, 0, 1, 1);
        vecs[12] = mk(0, 1, 8'h0f, 0, 8'h00, 0, 3, 4, 0, 0, 0, 1, 1);
        vecs[13] = mk(0, 1, 8'hf0, 0, 8'h00, 0, 4, 4, 0, 0, 0, 1, 1);
        vecs[14] = mk(1, 0, 8'h00, 0, 8'h00, 0, 4, 0, 0, 0, 1, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 1, 8'h21, 0, 3, 1, 0, 0, 1, 0, 0);
        vecs[16] = mk(0, 0, 8'h00, 1, 8'h03, 1, 2, 1, 1, 1, 1, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 1, 8'h0f, 0, 1, 2, 1, 0, 1, 0, 0);
        vecs[18] = mk(0, 0, 8'h00, 1, 8'hf0, 0, 0, 3, 1, 0, 0, 1, 0);

        idle();
        tick();
        do_reset();

        // Reset state
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.pass", bus.pass, 0);
        check("rst.q_count", bus.q_count, 0);
        check("rst.pass_cnt", bus.pass_cnt, 0);
        check("rst.fail_cnt", bus.fail_cnt, 0);
        check("rst.mismatch", bus.mismatch, 0);
        check("rst.underrun", bus.underrun, 0);
        check("rst.overflow", bus.overflow, 0);
        check("rst.ff_got", bus.first_fail_got, 0);

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].st, vecs[i].wr, vecs[i].d, 8'hFF, vecs[i].sv, vecs[i].y, vecs[i].fl);
            tick();
            check($sformatf("vec%0d.q_count", i), bus.q_count, vecs[i].q);
            check($sformatf("vec%0d.pass_cnt", i), bus.pass_cnt, vecs[i].pc);
            check($sformatf("vec%0d.fail_cnt", i), bus.fail_cnt, vecs[i].fc);
            check($sformatf("vec%0d.mismatch", i), bus.mismatch, vecs[i].mm);
            check($sformatf("vec%0d.busy", i), bus.busy, vecs[i].busy);
            check($sformatf("vec%0d.done", i), bus.done, vecs[i].done);
            check($sformatf("vec%0d.pass", i), bus.pass, vecs[i].pass);
        end
        check("fail1.ff_got", bus.first_fail_got, 8'h03);
        check("fail1.ff_exp", bus.first_fail_exp, 8'h01);
        check("fail1.ff_idx", bus.first_fail_idx, 1);
        check("fail1.ff_flag", bus.first_fail_flag, 1);

        // Underrun: only one entry queued for a four-sample run
        do_reset();
        push(8'h21);
        do_start();
        sample(8'h21, 0);
        check("und.pass_cnt", bus.pass_cnt, 1);
        sample(8'h55, 0);
        check("und.fail_cnt", bus.fail_cnt, 1);
        check("und.underrun", bus.underrun, 1);
        check("und.q_count", bus.q_count, 0);
        check("und.mismatch", bus.mismatch, 1);
        check("und.ff_exp", bus.first_fail_exp, 8'h00);
        check("und.ff_got", bus.first_fail_got, 8'h55);
        check("und.ff_idx", bus.first_fail_idx, 1);
        sample(8'h00, 0);
        sample(8'h77, 1);
        check("und.fail_cnt_end", bus.fail_cnt, 3);
        check("und.done", bus.done, 1);
        check("und.pass", bus.pass, 0);
        check("und.ff_got_kept", bus.first_fail_got, 8'h55);

        // Full / overflow, then push+pop while full
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(i));
        check("ovf.q_count", bus.q_count, 8);
        check("ovf.overflow", bus.overflow, 1);
        do_start();
        check("ovf.cleared_by_start", bus.overflow, 0);
        drive(0, 1, 8'h09, 8'hFF, 1, 8'h00, 0);
        tick();
        check("ovf.pushpop_q_count", bus.q_count, 8);
        check("ovf.pushpop_overflow", bus.overflow, 0);
        check("ovf.pushpop_pass_cnt", bus.pass_cnt, 1);
        for (int i = 1; i < 4; i++) sample(8'(i), 0);
        check("ovf.run1_pass", bus.pass, 1);
        do_start();
        for (int i = 4; i < 8; i++) sample(8'(i), 0);
        check("ovf.run2_pass_cnt", bus.pass_cnt, 4);
        do_start();
        sample(8'h09, 0);
        check("ovf.lost_entry_pass_cnt", bus.pass_cnt, 1);
        check("ovf.lost_entry_fail_cnt", bus.fail_cnt, 0);
        check("ovf.drained", bus.q_count, 0);

        // Reset in the middle of a run
        do_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        do_start();
        sample(8'h11, 0);
        sample(8'h99, 0);
        do_reset();
        check("rmid.busy", bus.busy, 0);
        check("rmid.done", bus.done, 0);
        check("rmid.pass_cnt", bus.pass_cnt, 0);
        check("rmid.fail_cnt", bus.fail_cnt, 0);
        check("rmid.q_count", bus.q_count, 0);
        check("rmid.ff_got", bus.first_fail_got, 0);
        sample(8'h55, 0);
        check("rmid.idle_fail_cnt", bus.fail_cnt, 0);
        check("rmid.idle_underrun", bus.underrun, 0);
        drive(0, 1, 8'h66, 8'hFF, 1, 8'h66, 0);
        tick();
        check("rmid.idle_no_pop", bus.q_count, 1);
        check("rmid.idle_pass_cnt", bus.pass_cnt, 0);

`ifdef CHECK_MASK_EN
        // Masked compare: low nibble checked, high nibble ignored
        do_reset();
        drive(0, 1, 8'h0f, 8'h0F, 0, 8'h00, 0); tick();
        drive(0, 1, 8'h0f, 8'h0F, 0, 8'h00, 0); tick();
        do_start();
        sample(8'hAF, 0);
        check("mask.pass_cnt", bus.pass_cnt, 1);
        check("mask.fail_cnt0", bus.fail_cnt, 0);
        sample(8'h0E, 0);
        check("mask.fail_cnt1", bus.fail_cnt, 1);
        check("mask.mismatch", bus.mismatch, 1);
`endif

        // Randomized phase against the reference model
        do_reset();
        model_step(1, 0, 0, 0, 8'hFF, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            bit         r_rst, st, wr, sv, fl;
            logic [7:0] d, m, y;
            r_rst = ($urandom_range(0, 149) == 0);
            st    = ($urandom_range(0, 11) == 0);
            wr    = ($urandom_range(0, 99) < 55);
            d     = 8'($urandom_range(0, 255));
            m     = 8'hFF;
`ifdef CHECK_MASK_EN
            case ($urandom_range(0, 3))
                0:       m = 8'h0F;
                1:       m = 8'hF0;
                2:       m = 8'($urandom_range(0, 255));
                default: m = 8'hFF;
            endcase
`endif
            sv = ($urandom_range(0, 99) < 60);
            fl = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 99) < 75)
                y = mq[0] ^ (8'($urandom_range(0, 255)) & ~mkq[0]);
            else
                y = 8'($urandom_range(0, 255));
            drive(st, wr, d, m, sv, y, fl);
            rst = r_rst;
            tick();
            rst = 1'b0;
            model_step(r_rst, st, wr, d, m, sv, y, fl);
            compare_model(c);
        end

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
